design_exerciser: RTL and testbench

Self-checking stimulus/response engine for the on-fabric 4-input test design. Drives every 4-bit input vector into the mapped design under test (DUT), samples its combinational and registered outputs, and compares them against a golden model. Pass/fail, error count and first failing vector are reported to the board-level status logic. It sits alongside the DUT inside the same clock domain.

---
 rtl/exerciser_pkg.sv | 23 ++
 rtl/design_golden_model.sv | 17 +
 rtl/design_exerciser.sv | 143 ++++++++++++++
 tb/tb_design_exerciser.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/exerciser_pkg.sv
// Shared types and widths for the design exerciser and its golden model.
package exerciser_pkg;

   localparam int unsigned VECTOR_W = 4;
   localparam int unsigned ERR_W    = 8;
   localparam int unsigned ERR_MAX  = 255;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      APPLY = 2'd1,
      HOLD  = 2'd2,
      DONE  = 2'd3
   } state_t;

   // Expected response of the 4-input test design for one stimulus vector
   typedef struct packed {
      logic [1:0] out;
      logic       const_val;
      logic       more_logic;
      logic       ff;
   } golden_t;

endpackage

// File: rtl/design_golden_model.sv
// Combinational reference for the 4-input test design; ff is the value the
// DUT register holds one edge after the vector is applied.
module design_golden_model
   import exerciser_pkg::*;
(
   input  logic [VECTOR_W-1:0] vector,
   output golden_t             expected
);

   always_comb begin
      expected.out        = {vector[2] | vector[3], vector[0] & vector[1]};
      expected.const_val  = 1'b1;
      expected.more_logic = ~(vector[2] | vector[3]);
      expected.ff         = vector[0] | ~vector[1];
   end

endmodule

// File: rtl/design_exerciser.sv
// Sweeps all 4-bit vectors through the on-fabric test design, checks each
// response against the golden model and reports pass/fail statistics.
module design_exerciser
   import exerciser_pkg::*;
#(
   parameter int unsigned NUM_PASSES    = 1,
   parameter int unsigned SETTLE_CYCLES = 0
) (
   input  logic                i_Clock,
   input  logic                i_Reset,
   input  logic                i_Start,
   output logic                o_Busy,
   output logic                o_Done,
   output logic                o_Pass,
   output logic [ERR_W-1:0]    o_ErrorCount,
   output logic                o_FirstFailValid,
   output logic [VECTOR_W-1:0] o_FirstFailVector,
   output logic [VECTOR_W-1:0] o_DutInput,
   input  logic [1:0]          i_DutOutput,
   input  logic                i_DutOutputFF,
   input  logic                i_DutConst,
   input  logic                i_DutWithMoreLogic
);

   localparam int unsigned CNT_W  = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
   localparam int unsigned PASS_W = (NUM_PASSES > 1) ? $clog2(NUM_PASSES) : 1;

   state_t              state;
   state_t              next_state;
   logic [VECTOR_W-1:0] vec;
   logic [VECTOR_W-1:0] vec_next;
   logic [PASS_W-1:0]   pass_cnt;
   logic [CNT_W-1:0]    settle_cnt;
   logic                apply_miss;
   golden_t             expected;

   logic                settle_done;
   logic                last_vec;
   logic                last_pass;
   logic                comb_miss;
   logic                vec_fail;
   logic                in_run_next;
   logic [ERR_W-1:0]    err_next;

   design_golden_model u_golden (
      .vector   (vec),
      .expected (expected)
   );

   // State register
   always_ff @(posedge i_Clock) begin
      if (i_Reset) state <= IDLE;
      else         state <= next_state;
   end

   // Next state and next stimulus vector
   always_comb begin
      next_state = state;
      vec_next   = vec;
      case (state)
         IDLE: begin
            if (i_Start) begin
               next_state = APPLY;
               vec_next   = '0;
            end
         end
         APPLY: if (settle_done) next_state = HOLD;
         HOLD: begin
            vec_next   = vec + VECTOR_W'(1);
            next_state = (last_vec && last_pass) ? DONE : APPLY;
         end
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Compare decode and saturating error-count update
   always_comb begin
      settle_done = (settle_cnt == CNT_W'(SETTLE_CYCLES));
      last_vec    = (vec == {VECTOR_W{1'b1}});
      last_pass   = (pass_cnt == PASS_W'(NUM_PASSES - 1));
      comb_miss   = (i_DutOutput != expected.out) || (i_DutConst != expected.const_val) ||
                    (i_DutWithMoreLogic != expected.more_logic);
      vec_fail    = apply_miss || (i_DutOutputFF != expected.ff);
      in_run_next = (next_state == APPLY) || (next_state == HOLD);
      err_next    = o_ErrorCount;
      if (state == HOLD && vec_fail && o_ErrorCount != ERR_W'(ERR_MAX))
         err_next = o_ErrorCount + ERR_W'(1);
   end

   // Counters, stimulus and result registers
   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         vec               <= '0;
         pass_cnt          <= '0;
         settle_cnt        <= '0;
         apply_miss        <= 1'b0;
         o_Busy            <= 1'b0;
         o_Done            <= 1'b0;
         o_Pass            <= 1'b0;
         o_ErrorCount      <= '0;
         o_FirstFailValid  <= 1'b0;
         o_FirstFailVector <= '0;
         o_DutInput        <= '0;
      end else begin
         vec        <= vec_next;
         o_Busy     <= in_run_next;
         o_Done     <= (next_state == DONE);
         o_DutInput <= in_run_next ? vec_next : '0;
         case (state)
            IDLE: begin
               if (i_Start) begin
                  pass_cnt          <= '0;
                  settle_cnt        <= '0;
                  o_Pass            <= 1'b0;
                  o_ErrorCount      <= '0;
                  o_FirstFailValid  <= 1'b0;
                  o_FirstFailVector <= '0;
               end
            end
            APPLY: begin
               if (settle_done) begin
                  apply_miss <= comb_miss;
                  settle_cnt <= '0;
               end else begin
                  settle_cnt <= settle_cnt + CNT_W'(1);
               end
            end
            HOLD: begin
               o_ErrorCount <= err_next;
               if (vec_fail && !o_FirstFailValid) begin
                  o_FirstFailValid  <= 1'b1;
                  o_FirstFailVector <= vec;
               end
               if (last_vec && !last_pass) pass_cnt <= pass_cnt + PASS_W'(1);
               if (next_state == DONE) o_Pass <= (err_next == '0);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_design_exerciser.sv
// Self-checking bench: golden-model vector table plus scoreboarded full runs
// of three exerciser configurations against a behavioural DUT with faults.
module tb_design_exerciser;
   import exerciser_pkg::*;

   localparam int F_NONE  = 0;
   localparam int F_CONST = 1;
   localparam int F_OUT0  = 2;
   localparam int F_FFINV = 3;

   typedef struct {
      int busy;
      int err;
      int valid;
      int vec;
      int pass;
   } exp_t;

   typedef struct {
      int   unit;
      int   fault;
      exp_t exp;
   } run_t;

   typedef struct {
      logic [3:0] v;
      logic [1:0] out;
      logic       wml;
      logic       ff;
   } gv_t;

   logic       clk;
   logic [2:0] rst;
   logic [2:0] start;
   logic [2:0] busy;
   logic [2:0] done;
   logic [2:0] pass;
   logic [2:0] ffv;
   logic [7:0] err [3];
   logic [3:0] ffvec [3];
   logic [3:0] dut_in [3];
   logic [1:0] dut_out [3];
   logic [2:0] dut_cst;
   logic [2:0] dut_wml;
   logic [2:0] dut_ff;
   int         fault [3];

   logic [3:0] gm_vec;
   golden_t    gm_exp;

   int   n_vec;
   int   n_err;
   exp_t sb[$];
   run_t runs[7];
   gv_t  gtab[16];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   design_golden_model gm (.vector(gm_vec), .expected(gm_exp));

   design_exerciser #(.NUM_PASSES(1), .SETTLE_CYCLES(0)) dut0 (
      .i_Clock(clk), .i_Reset(rst[0]), .i_Start(start[0]), .o_Busy(busy[0]), .o_Done(done[0]),
      .o_Pass(pass[0]), .o_ErrorCount(err[0]), .o_FirstFailValid(ffv[0]),
      .o_FirstFailVector(ffvec[0]), .o_DutInput(dut_in[0]), .i_DutOutput(dut_out[0]),
      .i_DutOutputFF(dut_ff[0]), .i_DutConst(dut_cst[0]), .i_DutWithMoreLogic(dut_wml[0]));

   design_exerciser #(.NUM_PASSES(1), .SETTLE_CYCLES(2)) dut1 (
      .i_Clock(clk), .i_Reset(rst[1]), .i_Start(start[1]), .o_Busy(busy[1]), .o_Done(done[1]),
      .o_Pass(pass[1]), .o_ErrorCount(err[1]), .o_FirstFailValid(ffv[1]),
      .o_FirstFailVector(ffvec[1]), .o_DutInput(dut_in[1]), .i_DutOutput(dut_out[1]),
      .i_DutOutputFF(dut_ff[1]), .i_DutConst(dut_cst[1]), .i_DutWithMoreLogic(dut_wml[1]));

   design_exerciser #(.NUM_PASSES(20), .SETTLE_CYCLES(0)) dut2 (
      .i_Clock(clk), .i_Reset(rst[2]), .i_Start(start[2]), .o_Busy(busy[2]), .o_Done(done[2]),
      .o_Pass(pass[2]), .o_ErrorCount(err[2]), .o_FirstFailValid(ffv[2]),
      .o_FirstFailVector(ffvec[2]), .o_DutInput(dut_in[2]), .i_DutOutput(dut_out[2]),
      .i_DutOutputFF(dut_ff[2]), .i_DutConst(dut_cst[2]), .i_DutWithMoreLogic(dut_wml[2]));

   // Behavioural test design with injectable faults
   always_comb begin
      for (int u = 0; u < 3; u++) begin
         dut_out[u] = {dut_in[u][2] | dut_in[u][3], dut_in[u][0] & dut_in[u][1]};
         if (fault[u] == F_OUT0) dut_out[u][0] = 1'b0;
         dut_cst[u] = (fault[u] != F_CONST);
         dut_wml[u] = ~(dut_in[u][2] | dut_in[u][3]);
      end
   end

   always_ff @(posedge clk) begin
      for (int u = 0; u < 3; u++)
         dut_ff[u] <= (dut_in[u][0] | ~dut_in[u][1]) ^ (fault[u] == F_FFINV);
   end

   task automatic check(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_reset(input int u);
      check("rst_busy", int'(busy[u]), 0);
      check("rst_done", int'(done[u]), 0);
      check("rst_pass", int'(pass[u]), 0);
      check("rst_err", int'(err[u]), 0);
      check("rst_ffvalid", int'(ffv[u]), 0);
      check("rst_ffvec", int'(ffvec[u]), 0);
      check("rst_dutin", int'(dut_in[u]), 0);
   endtask

   // One run: start pulse, measure busy length, compare against scoreboard at done
   task automatic run(input int u, input bit restart);
      int   cnt;
      exp_t e;
      start[u] = 1'b1;
      @(negedge clk);
      start[u] = 1'b0;
      check("first_dutin", int'(dut_in[u]), 0);
      cnt = 0;
      while (busy[u] && cnt < 2000) begin
         cnt++;
         start[u] = restart && (cnt == 5);
         @(negedge clk);
      end
      start[u] = 1'b0;
      check("done_pulse", int'(done[u]), 1);
      check("done_dutin", int'(dut_in[u]), 0);
      if (sb.size() == 0) begin
         n_vec++;
         n_err++;
         $display("FAIL scoreboard_empty: got 0 entries expected 1");
      end else begin
         e = sb.pop_front();
         check("busy_len", cnt, e.busy);
         check("err_count", int'(err[u]), e.err);
         check("first_valid", int'(ffv[u]), e.valid);
         check("first_vec", int'(ffvec[u]), e.vec);
         check("pass", int'(pass[u]), e.pass);
      end
      @(negedge clk);
      check("done_clear", int'(done[u]), 0);
      check("idle_busy", int'(busy[u]), 0);
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      rst   = 3'b111;
      start = 3'b000;
      for (int u = 0; u < 3; u++) fault[u] = F_NONE;
      gm_vec = '0;

      gtab[0]  = '{4'd0,  2'b00, 1'b1, 1'b1};
      gtab[1]  = '{4'd1,  2'b00, 1'b1, 1'b1};
      gtab[2]  = '{4'd2,  2'b00, 1'b1, 1'b0};
      gtab[3]  = '{4'd3,  2'b01, 1'b1, 1'b1};
      gtab[4]  = '{4'd4,  2'b10, 1'b0, 1'b1};
      gtab[5]  = '{4'd5,  2'b10, 1'b0, 1'b1};
      gtab[6]  = '{4'd6,  2'b10, 1'b0, 1'b0};
      gtab[7]  = '{4'd7,  2'b11, 1'b0, 1'b1};
      gtab[8]  = '{4'd8,  2'b10, 1'b0, 1'b1};
      gtab[9]  = '{4'd9,  2'b10, 1'b0, 1'b1};
      gtab[10] = '{4'd10, 2'b10, 1'b0, 1'b0};
      gtab[11] = '{4'd11, 2'b11, 1'b0, 1'b1};
      gtab[12] = '{4'd12, 2'b10, 1'b0, 1'b1};
      gtab[13] = '{4'd13, 2'b10, 1'b0, 1'b1};
      gtab[14] = '{4'd14, 2'b10, 1'b0, 1'b0};
      gtab[15] = '{4'd15, 2'b11, 1'b0, 1'b1};

      runs[0] = '{0, F_NONE,  '{32,  0,   0, 0, 1}};
      runs[1] = '{0, F_CONST, '{32,  16,  1, 0, 0}};
      runs[2] = '{0, F_OUT0,  '{32,  4,   1, 3, 0}};
      runs[3] = '{1, F_FFINV, '{64,  16,  1, 0, 0}};
      runs[4] = '{1, F_NONE,  '{64,  0,   0, 0, 1}};
      runs[5] = '{2, F_CONST, '{640, 255, 1, 0, 0}};
      runs[6] = '{2, F_NONE,  '{640, 0,   0, 0, 1}};

      for (int i = 0; i < 16; i++) begin
         gm_vec = gtab[i].v;
         #1;
         check("gm_out", int'(gm_exp.out), int'(gtab[i].out));
         check("gm_const", int'(gm_exp.const_val), 1);
         check("gm_wml", int'(gm_exp.more_logic), int'(gtab[i].wml));
         check("gm_ff", int'(gm_exp.ff), int'(gtab[i].ff));
      end

      @(negedge clk);
      @(negedge clk);
      rst = 3'b000;
      for (int u = 0; u < 3; u++) check_reset(u);

      for (int i = 0; i < 7; i++) begin
         fault[runs[i].unit] = runs[i].fault;
         sb.push_back(runs[i].exp);
         run(runs[i].unit, 1'b0);
      end

      // Mid-run restart is ignored, then reset aborts the run
      fault[0] = F_CONST;
      start[0] = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 10; i++) begin
         start[0] = (i == 4);
         @(negedge clk);
      end
      start[0] = 1'b0;
      check("abort_busy", int'(busy[0]), 1);
      check("abort_err", int'(err[0]), 5);
      rst[0] = 1'b1;
      @(negedge clk);
      rst[0] = 1'b0;
      check_reset(0);
      fault[0] = F_NONE;
      sb.push_back('{32, 0, 0, 0, 1});
      run(0, 1'b1);

      // Reset and start together: reset wins and clears held results
      rst[0]   = 1'b1;
      start[0] = 1'b1;
      @(negedge clk);
      rst[0]   = 1'b0;
      start[0] = 1'b0;
      check_reset(0);
      @(negedge clk);
      check("no_start_after_rst", int'(busy[0]), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
